// File: rtl/id_ex_register.sv
// ID/EX pipeline register with branch squash, load-use bubble and hold.
// Define STALL_COUNTER_EN to build the saturating bubble counter on stall_count.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_IDEX,
    input  logic              flush_CtrlBits,
    input  logic              flush_branch,
    input  logic [DATA_W-1:0] pc4_IFID,
    input  logic [DATA_W-1:0] readData1_ID,
    input  logic [DATA_W-1:0] readData2_ID,
    input  logic [DATA_W-1:0] signExt_ID,
    input  logic [REG_W-1:0]  rs_IFID,
    input  logic [REG_W-1:0]  rt_IFID,
    input  logic [REG_W-1:0]  rd_IFID,
    input  logic              regWrite_ID,
    input  logic              memToReg_ID,
    input  logic              memRead_ID,
    input  logic              memWrite_ID,
    input  logic              branch_ID,
    input  logic              aluSrc_ID,
    input  logic              regDst_ID,
    input  logic [1:0]        aluOp_ID,
    output logic [DATA_W-1:0] pc4_IDEX,
    output logic [DATA_W-1:0] readData1_IDEX,
    output logic [DATA_W-1:0] readData2_IDEX,
    output logic [DATA_W-1:0] signExt_IDEX,
    output logic [REG_W-1:0]  rs_IDEX,
    output logic [REG_W-1:0]  rt_IDEX,
    output logic [REG_W-1:0]  rd_IDEX,
    output logic              regWrite_IDEX,
    output logic              memToReg_IDEX,
    output logic              memRead_IDEX,
    output logic              memWrite_IDEX,
    output logic              branch_IDEX,
    output logic              aluSrc_IDEX,
    output logic              regDst_IDEX,
    output logic [1:0]        aluOp_IDEX,
    output logic              valid_IDEX,
    output logic [15:0]       stall_count
);

    localparam int DP_W   = 4*DATA_W + 3*REG_W;
    localparam int CTRL_W = 9;

    logic [DP_W-1:0]   dp_in, dp_d, dp_q;
    logic [CTRL_W-1:0] ctrl_in, ctrl_d, ctrl_q;
    logic              valid_d, valid_q;

    assign dp_in = {pc4_IFID, readData1_ID, readData2_ID, signExt_ID,
                    rs_IFID, rt_IFID, rd_IFID};
    assign ctrl_in = {regWrite_ID, memToReg_ID, memRead_ID, memWrite_ID,
                      branch_ID, aluSrc_ID, regDst_ID, aluOp_ID};

    // Branch squash beats hold; hold beats bubble; bubble beats load.
    always_comb begin
        dp_d    = dp_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush_branch) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (!write_IDEX) begin
            dp_d = dp_q;
        end else if (flush_CtrlBits) begin
            dp_d    = dp_in;
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else begin
            dp_d    = dp_in;
            ctrl_d  = ctrl_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_q    <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dp_q    <= dp_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign {pc4_IDEX, readData1_IDEX, readData2_IDEX, signExt_IDEX,
            rs_IDEX, rt_IDEX, rd_IDEX} = dp_q;
    assign {regWrite_IDEX, memToReg_IDEX, memRead_IDEX, memWrite_IDEX,
            branch_IDEX, aluSrc_IDEX, regDst_IDEX, aluOp_IDEX} = ctrl_q;
    assign valid_IDEX = valid_q;

`ifdef STALL_COUNTER_EN
    logic        bubble;
    logic [15:0] cnt_d, cnt_q;

    assign bubble = write_IDEX & flush_CtrlBits & ~flush_branch;

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: vector table, scoreboard queue,
// plus reset and counter-saturation sequences.
module tb_id_ex_register;

    typedef struct packed {
        logic [31:0] pc4, rd1, rd2, sext;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
        logic        valid;
        logic [15:0] cnt;
    } st_t;

    typedef struct packed {
        logic        wr, fc, fb;
        logic [31:0] pc4, rd1, rd2, sext;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
        logic        exp_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write_IDEX, flush_CtrlBits, flush_branch;
    logic [31:0] pc4_IFID, readData1_ID, readData2_ID, signExt_ID;
    logic [4:0]  rs_IFID, rt_IFID, rd_IFID;
    logic        regWrite_ID, memToReg_ID, memRead_ID, memWrite_ID;
    logic        branch_ID, aluSrc_ID, regDst_ID;
    logic [1:0]  aluOp_ID;
    logic [31:0] pc4_IDEX, readData1_IDEX, readData2_IDEX, signExt_IDEX;
    logic [4:0]  rs_IDEX, rt_IDEX, rd_IDEX;
    logic        regWrite_IDEX, memToReg_IDEX, memRead_IDEX, memWrite_IDEX;
    logic        branch_IDEX, aluSrc_IDEX, regDst_IDEX;
    logic [1:0]  aluOp_IDEX;
    logic        valid_IDEX;
    logic [15:0] stall_count;

    id_ex_register dut (
        .clk(clk), .reset_n(reset_n),
        .write_IDEX(write_IDEX), .flush_CtrlBits(flush_CtrlBits),
        .flush_branch(flush_branch),
        .pc4_IFID(pc4_IFID), .readData1_ID(readData1_ID),
        .readData2_ID(readData2_ID), .signExt_ID(signExt_ID),
        .rs_IFID(rs_IFID), .rt_IFID(rt_IFID), .rd_IFID(rd_IFID),
        .regWrite_ID(regWrite_ID), .memToReg_ID(memToReg_ID),
        .memRead_ID(memRead_ID), .memWrite_ID(memWrite_ID),
        .branch_ID(branch_ID), .aluSrc_ID(aluSrc_ID),
        .regDst_ID(regDst_ID), .aluOp_ID(aluOp_ID),
        .pc4_IDEX(pc4_IDEX), .readData1_IDEX(readData1_IDEX),
        .readData2_IDEX(readData2_IDEX), .signExt_IDEX(signExt_IDEX),
        .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX), .rd_IDEX(rd_IDEX),
        .regWrite_IDEX(regWrite_IDEX), .memToReg_IDEX(memToReg_IDEX),
        .memRead_IDEX(memRead_IDEX), .memWrite_IDEX(memWrite_IDEX),
        .branch_IDEX(branch_IDEX), .aluSrc_IDEX(aluSrc_IDEX),
        .regDst_IDEX(regDst_IDEX), .aluOp_IDEX(aluOp_IDEX),
        .valid_IDEX(valid_IDEX), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    st_t  exp_s;
    st_t  sb[$];
    vec_t tbl[11];

    function automatic st_t actual();
        st_t a;
        a.pc4 = pc4_IDEX; a.rd1 = readData1_IDEX;
        a.rd2 = readData2_IDEX; a.sext = signExt_IDEX;
        a.rs = rs_IDEX; a.rt = rt_IDEX; a.rd = rd_IDEX;
        a.ctrl = {regWrite_IDEX, memToReg_IDEX, memRead_IDEX, memWrite_IDEX,
                  branch_IDEX, aluSrc_IDEX, regDst_IDEX, aluOp_IDEX};
        a.valid = valid_IDEX;
        a.cnt = stall_count;
        return a;
    endfunction

    // Reference behaviour: squash > hold > bubble > load.
    function automatic st_t model(st_t s, vec_t v);
        st_t n = s;
        if (v.fb) begin
            n.ctrl = '0; n.valid = 1'b0;
        end else if (!v.wr) begin
            n = s;
        end else begin
            n.pc4 = v.pc4; n.rd1 = v.rd1; n.rd2 = v.rd2; n.sext = v.sext;
            n.rs = v.rs; n.rt = v.rt; n.rd = v.rd;
            if (v.fc) begin
                n.ctrl = '0; n.valid = 1'b0;
`ifdef STALL_COUNTER_EN
                if (s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
`endif
            end else begin
                n.ctrl = v.ctrl; n.valid = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic cmp(string name, logic [255:0] got, logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, want);
        end
    endtask

    task automatic drive(vec_t v);
        write_IDEX = v.wr; flush_CtrlBits = v.fc; flush_branch = v.fb;
        pc4_IFID = v.pc4; readData1_ID = v.rd1;
        readData2_ID = v.rd2; signExt_ID = v.sext;
        rs_IFID = v.rs; rt_IFID = v.rt; rd_IFID = v.rd;
        {regWrite_ID, memToReg_ID, memRead_ID, memWrite_ID,
         branch_ID, aluSrc_ID, regDst_ID, aluOp_ID} = v.ctrl;
    endtask

    task automatic step(vec_t v, string name, bit do_chk);
        st_t e;
        exp_s = model(exp_s, v);
        sb.push_back(exp_s);
        drive(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (do_chk) cmp(name, 256'(actual()), 256'(e));
    endtask

    function automatic vec_t mk(logic wr, logic fc, logic fb,
                                logic [31:0] pc4, logic [4:0] rt,
                                logic [8:0] ctrl, logic ev);
        vec_t v;
        v.wr = wr; v.fc = fc; v.fb = fb;
        v.pc4 = pc4; v.rd1 = pc4 ^ 32'hA5A5_0000;
        v.rd2 = ~pc4; v.sext = pc4 + 32'd100;
        v.rs = rt + 5'd1; v.rt = rt; v.rd = rt + 5'd2;
        v.ctrl = ctrl; v.exp_valid = ev;
        return v;
    endfunction

    vec_t tmp;

    initial begin
        // ctrl = {regWrite,memToReg,memRead,memWrite,branch,aluSrc,regDst,aluOp}
        tbl[0]  = mk(1, 0, 0, 32'h0000_0004, 5'd3,  9'b1_0000_0010, 1);
        tbl[1]  = mk(1, 1, 0, 32'h0000_0008, 5'd8,  9'b0_0100_0000, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0000_000C, 5'd9,  9'b1_1100_1000, 1);
        tbl[3]  = mk(0, 0, 0, 32'h1111_1111, 5'd10, 9'b0_0011_1101, 1);
        tbl[4]  = mk(0, 1, 0, 32'h2222_2222, 5'd11, 9'b1_1111_1111, 1);
        tbl[5]  = mk(0, 0, 0, 32'h3333_3333, 5'd12, 9'b0_1010_1010, 1);
        tbl[6]  = mk(0, 1, 1, 32'h4444_4444, 5'd13, 9'b1_1111_1111, 0);
        tbl[7]  = mk(1, 0, 0, 32'h0000_0010, 5'd14, 9'b0_0001_0101, 1);
        tbl[8]  = mk(1, 0, 1, 32'h5555_5555, 5'd15, 9'b1_1111_1111, 0);
        tbl[9]  = mk(0, 1, 0, 32'h6666_6666, 5'd16, 9'b1_0101_0101, 0);
        tbl[10] = mk(1, 0, 0, 32'hFFFF_FFFC, 5'd31, 9'b1_1111_1111, 1);

        exp_s = '0;
        tmp = mk(0, 0, 0, 32'h0, 5'd0, 9'h0, 0);
        drive(tmp);
        reset_n = 1'b0;
        #3;
        cmp("reset_state", 256'(actual()), 256'(st_t'('0)));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i], $sformatf("vec%0d", i), 1'b1);
            cmp($sformatf("vec%0d_valid", i),
                256'(valid_IDEX), 256'(tbl[i].exp_valid));
        end

        // Async reset in mid-cycle clears everything before the next edge.
        #1;
        reset_n = 1'b0;
        #1;
        exp_s = '0;
        cmp("async_reset", 256'(actual()), 256'(st_t'('0)));
        #1;
        reset_n = 1'b1;
        tmp = mk(1, 0, 0, 32'h0000_0020, 5'd7, 9'b1_0010_0001, 1);
        step(tmp, "post_reset_load", 1'b1);

        // Saturation: 65537 bubbles from a fresh counter.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        exp_s = '0;
        for (int i = 0; i < 65537; i++) begin
            tmp = mk(1, 1, 0, 32'($urandom), 5'($urandom),
                     9'($urandom), 0);
            step(tmp, "sat_bubble",
                 (i < 3) || (i % 8192 == 0) || (i >= 65533));
        end
`ifdef STALL_COUNTER_EN
        cmp("stall_sat", 256'(stall_count), 256'(16'hFFFF));
`else
        cmp("stall_tied", 256'(stall_count), 256'(16'h0000));
`endif
        cmp("sat_memread", 256'(memRead_IDEX), 256'(1'b0));
        cmp("sb_empty", 256'(sb.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
